// File: rtl/mc6809_bus_bridge_pkg.sv
// Shared types and constants for the 6809-to-SPI-flash bus bridge.
package mtl1_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_HOLD,
    ST_WR_CAPT,
    ST_WR_REQ
  } state_e;

  // Number of upper address bits compared against the window base.
  localparam int WIN_CMP_W = 4;

  // Byte returned to the CPU when a read is abandoned on timeout.
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  typedef struct packed {
    logic        rw;
    logic [11:0] addr;
    logic [7:0]  wdata;
  } req_t;

  function automatic logic win_hit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:16-WIN_CMP_W] == base[15:16-WIN_CMP_W];
  endfunction

endpackage

// File: rtl/mc6809_bus_bridge_if.sv
// CPU bus, flash request port and CPU handshake signals of the bridge.
interface mc6809_bus_bridge_if;
  logic        i_E;
  logic        i_Q;
  logic [15:0] i_ADDRESS_BUS;
  logic [7:0]  i_DataBus;
  logic        i_RW;
  logic        o_req_valid;
  logic        o_req_rw;
  logic [11:0] o_req_addr;
  logic [7:0]  o_req_wdata;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [7:0]  i_rsp_rdata;
  logic        o_MRDY;
  logic        o_data_oe;
  logic [7:0]  o_DataBus;
  logic        o_timeout;

  // Bridge side.
  modport slave (
    input  i_E, i_Q, i_ADDRESS_BUS, i_DataBus, i_RW,
    input  i_req_ready, i_rsp_valid, i_rsp_rdata,
    output o_req_valid, o_req_rw, o_req_addr, o_req_wdata,
    output o_MRDY, o_data_oe, o_DataBus, o_timeout
  );

  // Environment side (CPU and flash controller).
  modport master (
    output i_E, i_Q, i_ADDRESS_BUS, i_DataBus, i_RW,
    output i_req_ready, i_rsp_valid, i_rsp_rdata,
    input  o_req_valid, o_req_rw, o_req_addr, o_req_wdata,
    input  o_MRDY, o_data_oe, o_DataBus, o_timeout
  );
endinterface

// File: rtl/mc6809_bus_bridge_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level with registered edge strobes.
// The strobes are computed one stage early so they line up with the
// synchronised level rather than lagging it by a clock.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic q_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Next-state: shift the chain, detect transitions entering the last stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    rise_d = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    fall_d = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
  end

  // Register the chain and strobes; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_sync = sync_q[SYNC_STAGES-1];
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/mc6809_bus_bridge.sv
// 6809 bus front end: decodes a 4 KB flash window, turns each hit into one
// valid/ready request, and stretches reads with MRDY until data returns.
module mc6809_bus_bridge
  import mtl1_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hE000,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [15:0] MRDY_TIMEOUT = 16'd4000
) (
  input logic                 clk,
  input logic                 reset,
  mc6809_bus_bridge_if.slave  bus
);

  logic e_sync, e_rise, e_fall;
  logic q_sync, q_rise, q_fall;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
    .clk(clk), .reset(reset), .d_async(bus.i_E),
    .q_sync(e_sync), .rise(e_rise), .fall(e_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
    .clk(clk), .reset(reset), .d_async(bus.i_Q),
    .q_sync(q_sync), .rise(q_rise), .fall(q_fall)
  );

  // Only E fall and Q rise drive the bridge; the other edges are spare.
  logic unused_edges;
  assign unused_edges = e_rise ^ q_sync ^ q_fall;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        req_valid_q, req_valid_d;
  logic        mrdy_q, mrdy_d;
  logic        oe_q, oe_d;
  logic [7:0]  dbus_q, dbus_d;
  logic        tmo_q, tmo_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  wcap_q, wcap_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_rw_q, pend_rw_d;
  logic [11:0] pend_addr_q, pend_addr_d;

  logic hit, tmo_hit, rsp_take;

  assign hit      = q_rise && win_hit(bus.i_ADDRESS_BUS, BASE_ADDR);
  assign tmo_hit  = !mrdy_q && (tmo_cnt_q == MRDY_TIMEOUT - 16'd1);
  assign rsp_take = (state_q == ST_RD_WAIT) && bus.i_rsp_valid;

  // Next-state and output logic for the bus-cycle FSM and its side registers.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_valid_d  = req_valid_q;
    mrdy_d       = mrdy_q;
    oe_d         = oe_q;
    dbus_d       = dbus_q;
    tmo_d        = 1'b0;
    tmo_cnt_d    = mrdy_q ? 16'd0 : tmo_cnt_q + 16'd1;
    wcap_d       = e_sync ? bus.i_DataBus : wcap_q;
    pend_valid_d = pend_valid_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          req_d.addr = bus.i_ADDRESS_BUS[11:0];
          if (bus.i_RW) begin
            req_d.rw    = 1'b1;
            req_valid_d = 1'b1;
            mrdy_d      = 1'b0;
            state_d     = ST_RD_REQ;
          end else begin
            state_d = ST_WR_CAPT;
          end
        end
      end
      ST_RD_REQ: begin
        if (bus.i_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (bus.i_rsp_valid) begin
          dbus_d  = bus.i_rsp_rdata;
          oe_d    = 1'b1;
          mrdy_d  = 1'b1;
          state_d = ST_RD_HOLD;
        end
      end
      ST_RD_HOLD: begin
        if (e_fall) begin
          oe_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_WR_CAPT: begin
        if (e_fall) begin
          req_d.wdata = wcap_q;
          req_d.rw    = 1'b0;
          req_valid_d = 1'b1;
          state_d     = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        // A hit behind a posted write is parked and the CPU stretched.
        if (hit && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_rw_d    = bus.i_RW;
          pend_addr_d  = bus.i_ADDRESS_BUS[11:0];
          mrdy_d       = 1'b0;
        end
        if (bus.i_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if (pend_valid_d) begin
            pend_valid_d = 1'b0;
            req_d.addr   = pend_addr_d;
            if (pend_rw_d) begin
              req_d.rw    = 1'b1;
              req_valid_d = 1'b1;
              state_d     = ST_RD_REQ;
            end else begin
              mrdy_d  = 1'b1;
              state_d = ST_WR_CAPT;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout abandons whatever is stalling the CPU; a response on the same clk wins.
    if (tmo_hit && !rsp_take) begin
      tmo_d        = 1'b1;
      dbus_d       = TIMEOUT_FILL;
      oe_d         = 1'b1;
      mrdy_d       = 1'b1;
      req_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
      state_d      = ST_RD_HOLD;
    end
  end

  // State and registered outputs; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '{rw: 1'b1, addr: 12'h000, wdata: 8'h00};
      req_valid_q  <= 1'b0;
      mrdy_q       <= 1'b1;
      oe_q         <= 1'b0;
      dbus_q       <= 8'h00;
      tmo_q        <= 1'b0;
      tmo_cnt_q    <= 16'd0;
      wcap_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      pend_rw_q    <= 1'b1;
      pend_addr_q  <= 12'h000;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      mrdy_q       <= mrdy_d;
      oe_q         <= oe_d;
      dbus_q       <= dbus_d;
      tmo_q        <= tmo_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wcap_q       <= wcap_d;
      pend_valid_q <= pend_valid_d;
      pend_rw_q    <= pend_rw_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign bus.o_req_valid = req_valid_q;
  assign bus.o_req_rw    = req_q.rw;
  assign bus.o_req_addr  = req_q.addr;
  assign bus.o_req_wdata = req_q.wdata;
  assign bus.o_MRDY      = mrdy_q;
  assign bus.o_data_oe   = oe_q;
  assign bus.o_DataBus   = dbus_q;
  assign bus.o_timeout   = tmo_q;

endmodule
